piso_serializer: RTL

Parallel-in/serial-out stage that sits directly upstream of the serial pattern detector. It accepts W-bit words on a valid/ready handshake and drives them one bit per clock onto the detector's single-bit serial input. The detector samples every clock and has no enable, so this block defines the bit stream exactly, including idle fill between words. It also keeps a count of words sent, for debug.

---
 rtl/serial_pkg.sv | 19 +
 rtl/piso_serializer.sv | 120 ++++++++++++
 2 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serializer and the detector-side harness.
//   ser_state_e  : symbolic serializer states, for harness/debug use
//   ST_IDLE/SHIFT: the same encodings as plain logic constants, used by the RTL
//   SER_W        : default word width
//   SER_IDLE_BIT : default value driven on the serial line between words
package serial_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    localparam int unsigned SER_W        = 8;
    localparam logic        SER_IDLE_BIT = 1'b0;

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out stage feeding the serial pattern detector.
// Accepts W-bit words on a valid/ready handshake and emits one bit per clock.
// The next word can be accepted while the last bit of the current one is on
// the line, so back-to-back words produce a gapless stream.
//
// Ports:
//   clk        : rising-edge clock
//   rst        : synchronous reset, active-low
//   din        : parallel word to transmit
//   din_valid  : din holds a valid word
//   din_ready  : word will be taken at the next posedge (0 during reset)
//   sout       : serial bit (IDLE_BIT between words)
//   sout_valid : sout carries a data bit
//   last_bit   : sout carries the final bit of the current word
//   word_cnt   : words fully transmitted, wraps modulo 2^CNT_W
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | no word in flight; sout shows idle fill
// SHIFT | word in flight; bit_cnt counts remaining bits down to 0
module piso_serializer
    import serial_pkg::*;
#(
    parameter int unsigned W         = SER_W,
    parameter bit          LSB_FIRST = 1'b0,
    parameter logic        IDLE_BIT  = SER_IDLE_BIT,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             last_bit,
    output logic [CNT_W-1:0] word_cnt
);

    localparam int unsigned    BCW          = $clog2(W);
    localparam logic [BCW-1:0] BIT_CNT_LOAD = BCW'(W - 1);

    logic [0:0]       state_q,      state_d;
    logic [W-1:0]     shift_reg_q,  shift_reg_d;
    logic [BCW-1:0]   bit_cnt_q,    bit_cnt_d;
    logic [CNT_W-1:0] word_cnt_q,   word_cnt_d;
    logic             sout_q,       sout_d;
    logic             sout_valid_q, sout_valid_d;
    logic             last_bit_q,   last_bit_d;

    logic word_end;
    logic xfer;

    assign word_end  = (state_q == ST_SHIFT) && (bit_cnt_q == '0);
    assign din_ready = rst && ((state_q == ST_IDLE) || word_end);
    assign xfer      = din_valid && din_ready;

    always_comb begin
        state_d     = state_q;
        shift_reg_d = shift_reg_q;
        bit_cnt_d   = bit_cnt_q;
        word_cnt_d  = word_cnt_q;

        if (word_end) begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
            state_d    = ST_IDLE;
        end else if (state_q == ST_SHIFT) begin
            // Move the next bit into the output position.
            if (LSB_FIRST) begin
                shift_reg_d = {1'b0, shift_reg_q[W-1:1]};
            end else begin
                shift_reg_d = {shift_reg_q[W-2:0], 1'b0};
            end
            bit_cnt_d = bit_cnt_q - BCW'(1);
        end

        // A transfer on the last-bit cycle overrides the return to IDLE.
        if (xfer) begin
            shift_reg_d = din;
            bit_cnt_d   = BIT_CNT_LOAD;
            state_d     = ST_SHIFT;
        end

        // Outputs are registered from the next-state values so the first
        // bit appears the cycle right after acceptance.
        sout_valid_d = (state_d == ST_SHIFT);
        if (sout_valid_d) begin
            sout_d = LSB_FIRST ? shift_reg_d[0] : shift_reg_d[W-1];
        end else begin
            sout_d = IDLE_BIT;
        end
        last_bit_d = sout_valid_d && (bit_cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            shift_reg_q  <= '0;
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            sout_q       <= IDLE_BIT;
            sout_valid_q <= 1'b0;
            last_bit_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_reg_q  <= shift_reg_d;
            bit_cnt_q    <= bit_cnt_d;
            word_cnt_q   <= word_cnt_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            last_bit_q   <= last_bit_d;
        end
    end

    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign last_bit   = last_bit_q;
    assign word_cnt   = word_cnt_q;

endmodule
